decode_pipe_stage: RTL
======================

Name: decode_pipe_stage

Overview:
Parametrised decode stage with an integrated register file and a registered ID/EX output.
- Splits the instruction into fields and reads both source operands.
- Detects load-use hazards and stalls with a bubble.
- Connects to fetch and execute through valid/ready handshakes and supports a flush.
- Replaces the purely combinational decode. The register file, PC-as-source selection and field extraction remain; pipelining, stall logic and backpressure are new.

Parameters:
WIDTH, 32, data and PC width
REGNUM, 16, number of architectural registers; register REGNUM-1 reads as the PC
ADDRESSWIDTH, 4, register address width (clog2 of REGNUM)
OPCODEWIDTH, 4, opcode field width
INSTRUCTIONWIDTH, 24, instruction width
IMMWIDTH, 16, immediate field width (low bits of the instruction)
LOADOPCODE, 4'd2, opcode value that marks a memory load

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
inValid  in  1  fetch presents an instruction
inReady  out  1  stage can accept an instruction
instruction  in  INSTRUCTIONWIDTH  instruction word
PCPlus8  in  WIDTH  PC+8 paired with the instruction
obtainPCAsR1  in  1  force the rs1 address to REGNUM-1
writeEnable  in  1  writeback strobe
writeAddress  in  ADDRESSWIDTH  writeback register
dataToSave  in  WIDTH  writeback data
flush  in  1  kill the held and incoming instruction
outValid  out  1  ID/EX register holds a valid instruction
outReady  in  1  execute accepts the ID/EX contents
opcode  out  OPCODEWIDTH  registered opcode
regDestinationAddress  out  ADDRESSWIDTH  registered rd
reg1FinalAddress  out  ADDRESSWIDTH  registered rs1 after PC selection
reg2Address  out  ADDRESSWIDTH  registered rs2
reg1Content  out  WIDTH  registered rs1 value
reg2Content  out  WIDTH  registered rs2 value
inmediate  out  WIDTH  registered immediate, zero-extended
stall  out  1  load-use bubble inserted this cycle

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Field map, MSB first: opcode [IW-1 -: OW], rd next AW bits, rs1 next AW bits, rs2 next AW bits. Immediate is [IMMWIDTH-1:0], zero-extended to WIDTH. Defaults give opcode[23:20], rd[19:16], rs1[15:12], rs2[11:8], imm[15:0].
- rs1 address is REGNUM-1 when obtainPCAsR1=1, otherwise the field value.
- Register file:
  - REGNUM-1 entries are writable.
  - Reading REGNUM-1 returns PCPlus8.
  - Writes to REGNUM-1 are ignored.
  - Writes occur on the rising edge when writeEnable=1.
- Reset (reset=0 at an edge):
  - outValid=0, stall=0.
  - All registered outputs are 0 and the load-tracking register is cleared.
  - Register file contents are NOT cleared.
  - Reset asserted mid-stall drops the stalled instruction.
- Advance = !outValid || outReady.
- Load-use hazard: the ID/EX register holds a valid LOADOPCODE instruction with rd == rs1 or rd == rs2 of the incoming instruction. Exception: rs1 forced to PC does not count.
- Handshake and latency:
  - inReady = advance && !hazard.
  - Transfer in occurs when inValid && inReady. The ID/EX register loads on that edge, so latency is 1 cycle to outValid.
  - When advance && hazard: ID/EX loads a bubble (outValid=0), stall=1 for that cycle, and the instruction is held upstream.
  - When !advance: ID/EX contents are held stable and stall=0.
- flush=1: next edge sets outValid=0 and discards the incoming instruction. inReady=1 that cycle so fetch drains. flush overrides hazard and backpressure.
- Same-cycle write and read of the same address: see the optional feature.
- Reading register 0 returns the stored value; it is not hardwired to zero.

Optional Feature:
DECODE_WB_BYPASS_EN
- Defined: when writeEnable=1 and writeAddress matches a read address (other than REGNUM-1), the read returns dataToSave in the same cycle (write-through).
- Undefined: the read returns the pre-write value; the newly written value is visible from the next cycle.

Test Plan:
- Reset: hold reset=0 for 2 edges with inValid=1 -> outValid=0, all outputs 0, stall=0. After release, the first instruction appears 1 cycle after acceptance.
- Basic decode: write R3=0x11, R4=0x22, then send 24'h135400 with outReady=1 -> next cycle opcode=1, rd=3, rs1=5, rs2=4, reg2Content=0x22, inmediate=0x5400.
- PC select: obtainPCAsR1=1, PCPlus8=0x108 -> reg1FinalAddress=15, reg1Content=0x108. A write to R15 leaves the next read at PCPlus8.
- Load-use: load with rd=5 followed by an instruction with rs1=5 -> one bubble, stall=1 and inReady=0 for exactly one cycle, then the dependent instruction issues.
- Backpressure and flush: outReady=0 for 3 cycles -> outputs stable and inReady=0. Then flush=1 -> outValid=0 next cycle and the instruction presented that cycle is dropped.
- Bypass: writeEnable=1, writeAddress=6, dataToSave=0xAB while decoding rs2=6 -> reg2Content=0xAB with DECODE_WB_BYPASS_EN defined, the old value without it.

Source files
------------

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pipe_stage
//  Purpose  : Decode stage with integrated register file, load-use stall
//             detection, valid/ready handshakes, flush, and a registered
//             ID/EX output.
//  Options  : DECODE_WB_BYPASS_EN - when defined, a writeback to a register
//             being read this cycle is forwarded to the read (write-through).
//  Revision : 1.0 - initial pipelined release
// ============================================================================
module decode_pipe_stage #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int IMMWIDTH         = 16,
  parameter logic [OPCODEWIDTH-1:0] LOADOPCODE = 4'd2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  input  logic [WIDTH-1:0]            PCPlus8,
  input  logic                        obtainPCAsR1,
  input  logic                        writeEnable,
  input  logic [ADDRESSWIDTH-1:0]     writeAddress,
  input  logic [WIDTH-1:0]            dataToSave,
  input  logic                        flush,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [OPCODEWIDTH-1:0]      opcode,
  output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
  output logic [ADDRESSWIDTH-1:0]     reg1FinalAddress,
  output logic [ADDRESSWIDTH-1:0]     reg2Address,
  output logic [WIDTH-1:0]            reg1Content,
  output logic [WIDTH-1:0]            reg2Content,
  output logic [WIDTH-1:0]            inmediate,
  output logic                        stall
);

  localparam int IW = INSTRUCTIONWIDTH;
  localparam int OW = OPCODEWIDTH;
  localparam int AW = ADDRESSWIDTH;
  // The top register address is not storage: it reads back the PC.
  localparam logic [AW-1:0] c_PC_ADDR = AW'(REGNUM - 1);

  // Writable storage only; the PC alias has no entry.
  logic [WIDTH-1:0] r_regs [0:REGNUM-2];

  logic             r_valid;
  logic [OW-1:0]    r_opcode;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_rs1;
  logic [AW-1:0]    r_rs2;
  logic [WIDTH-1:0] r_rs1_val;
  logic [WIDTH-1:0] r_rs2_val;
  logic [WIDTH-1:0] r_imm;

  logic [OW-1:0]    w_opcode;
  logic [AW-1:0]    w_rd;
  logic [AW-1:0]    w_rs1_field;
  logic [AW-1:0]    w_rs1;
  logic [AW-1:0]    w_rs2;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;
  logic             w_advance;
  logic             w_hazard;

  // Field extraction, MSB first: opcode, rd, rs1, rs2; immediate from the LSBs.
  assign w_opcode    = instruction[IW-1 -: OW];
  assign w_rd        = instruction[IW-OW-1 -: AW];
  assign w_rs1_field = instruction[IW-OW-AW-1 -: AW];
  assign w_rs2       = instruction[IW-OW-2*AW-1 -: AW];
  assign w_imm       = WIDTH'(instruction[IMMWIDTH-1:0]);
  assign w_rs1       = obtainPCAsR1 ? c_PC_ADDR : w_rs1_field;

  // Register file write port; the PC alias silently ignores writes, and reset leaves contents intact.
  always_ff @(posedge clock) begin
    if (writeEnable && (writeAddress != c_PC_ADDR)) begin
      r_regs[writeAddress] <= dataToSave;
    end
  end

  // Two read ports: PC alias first, then optional same-cycle writeback forwarding, then storage.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 == c_PC_ADDR) begin
      w_rs1_val = PCPlus8;
`ifdef DECODE_WB_BYPASS_EN
    end else if (writeEnable && (writeAddress == w_rs1)) begin
      w_rs1_val = dataToSave;
`endif
    end else begin
      w_rs1_val = r_regs[w_rs1];
    end
    if (w_rs2 == c_PC_ADDR) begin
      w_rs2_val = PCPlus8;
`ifdef DECODE_WB_BYPASS_EN
    end else if (writeEnable && (writeAddress == w_rs2)) begin
      w_rs2_val = dataToSave;
`endif
    end else begin
      w_rs2_val = r_regs[w_rs2];
    end
  end

  // A held load whose rd feeds the incoming instruction must wait one cycle;
  // an rs1 forced to the PC never depends on a load.
  assign w_advance = !r_valid || outReady;
  assign w_hazard  = inValid && r_valid && (r_opcode == LOADOPCODE) &&
                     (((r_rd == w_rs1_field) && !obtainPCAsR1) || (r_rd == w_rs2));
  assign inReady   = flush || (w_advance && !w_hazard);
  assign stall     = !flush && w_advance && w_hazard;

  // ID/EX register: flush kills, backpressure holds, hazard inserts a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (inValid && !w_hazard) begin
        r_valid   <= 1'b1;
        r_opcode  <= w_opcode;
        r_rd      <= w_rd;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rs1_val <= w_rs1_val;
        r_rs2_val <= w_rs2_val;
        r_imm     <= w_imm;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign outValid              = r_valid;
  assign opcode                = r_opcode;
  assign regDestinationAddress = r_rd;
  assign reg1FinalAddress      = r_rs1;
  assign reg2Address           = r_rs2;
  assign reg1Content           = r_rs1_val;
  assign reg2Content           = r_rs2_val;
  assign inmediate             = r_imm;

endmodule
`default_nettype wire
